// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with registered pop data, status flags and
// optional sticky overflow/underflow flags (enabled by defining FIFO_ERR_EN).
module fifo_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pop,
  input  logic             push,
  input  logic             clear,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] P,
  output logic             pvalid,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_p;
  logic [AW-1:0]    r_rp, r_wp;
  logic [CW-1:0]    r_count;
  logic             r_pvalid, r_full, r_empty;
  logic             w_pop_ok, w_push_ok;
  logic [CW-1:0]    w_count_nxt;
  // A pop frees a slot in the same edge, so a full FIFO still accepts push+pop.
  assign w_pop_ok    = pop & (r_count != '0);
  assign w_push_ok   = push & ~clear & ((r_count != FULL_CNT) | w_pop_ok);
  assign w_count_nxt = clear ? '0 : r_count + CW'(w_push_ok) - CW'(w_pop_ok);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_p      <= '0;
      r_rp     <= '0;
      r_wp     <= '0;
      r_count  <= '0;
      r_pvalid <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_pop_ok) r_p <= r_mem[r_rp];
      r_rp     <= clear ? '0 : r_rp + AW'(w_pop_ok);
      r_wp     <= clear ? '0 : r_wp + AW'(w_push_ok);
      r_count  <= w_count_nxt;
      r_pvalid <= w_pop_ok;
      r_full   <= w_count_nxt == FULL_CNT;
      r_empty  <= w_count_nxt == '0;
    end
  always_ff @(posedge clk)
    if (w_push_ok) r_mem[r_wp] <= I;
`ifdef FIFO_ERR_EN
  logic r_ovf, r_unf;
  // Clear wipes the flags first; a same-edge rejected pop still sets underflow.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= ~clear & (r_ovf | (push & ~w_push_ok));
      r_unf <= (~clear & r_unf) | (pop & ~w_pop_ok);
    end
  assign overflow  = r_ovf;
  assign underflow = r_unf;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif
  assign P      = r_p;
  assign pvalid = r_pvalid;
  assign full   = r_full;
  assign empty  = r_empty;
  assign count  = r_count;
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed and randomized checks of fifo_param (WIDTH=8, DEPTH=4)
// against a queue-based reference model.
module tb_fifo_param;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pop = 1'b0, push = 1'b0, clear = 1'b0;
  logic [7:0] I = 8'h00;
  logic [7:0] P;
  logic       pvalid, full, empty, overflow, underflow;
  logic [2:0] count;
  int n_tests = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] m_p;
  logic       m_pv, m_ovf, m_unf;
  logic [15:0] w_dut;

  fifo_param #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pop(pop), .push(push), .clear(clear), .I(I),
    .P(P), .pvalid(pvalid), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;
  assign w_dut = {P, pvalid, count, full, empty, overflow, underflow};

  function automatic logic [15:0] exp_vec();
    logic eo, eu;
`ifdef FIFO_ERR_EN
    eo = m_ovf; eu = m_unf;
`else
    eo = 1'b0; eu = 1'b0;
`endif
    return {m_p, m_pv, 3'(q.size()), q.size() == 4, q.size() == 0, eo, eu};
  endfunction

  function automatic logic exp_unf();
`ifdef FIFO_ERR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    q.delete(); m_p = 8'h00; m_pv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // Drive one cycle, apply the behavioural rules at the edge, sample 1 time unit later.
  task automatic step(input logic pp, input logic ps, input logic cl, input logic [7:0] d);
    logic ok;
    pop = pp; push = ps; clear = cl; I = d;
    @(posedge clk);
    ok = pp && q.size() > 0;
    if (ok) m_p = q.pop_front();
    m_pv = ok;
    if (cl) begin
      q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (ps) begin
      if (q.size() < 4) q.push_back(d);
      else m_ovf = 1'b1;
    end
    if (pp && !ok) m_unf = 1'b1;
    #1;
    pop = 1'b0; push = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
    n_tests++; if (w_dut !== exp_vec()) begin n_fail++; $display("FAIL reset_vec dut=%h exp=%h", w_dut, exp_vec()); end
    n_tests++; if (empty !== 1'b1 || count !== 3'd0 || P !== 8'h00) begin n_fail++; $display("FAIL reset_state empty=%b count=%0d P=%h exp 1/0/00", empty, count, P); end
    reset = 1'b0;
  endtask

  task automatic test_fill_drain();
    logic [7:0] v[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) step(0, 1, 0, v[i]);
    n_tests++; if (full !== 1'b1 || count !== 3'd4) begin n_fail++; $display("FAIL fill full=%b count=%0d exp 1/4", full, count); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00);
      n_tests++; if (P !== v[i] || pvalid !== 1'b1) begin n_fail++; $display("FAIL drain[%0d] P=%h pvalid=%b exp %h/1", i, P, pvalid, v[i]); end
    end
    n_tests++; if (empty !== 1'b1 || w_dut !== exp_vec()) begin n_fail++; $display("FAIL drain_end dut=%h exp=%h", w_dut, exp_vec()); end
  endtask

  task automatic test_wrap();
    logic [7:0] v[4] = '{8'h03, 8'h04, 8'h05, 8'h06};
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 8'(i));
    step(1, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    for (int i = 4; i <= 6; i++) step(0, 1, 0, 8'(i));
    n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL wrap_count count=%0d exp 4", count); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00);
      n_tests++; if (P !== v[i] || w_dut !== exp_vec()) begin n_fail++; $display("FAIL wrap_pop[%0d] P=%h exp %h", i, P, v[i]); end
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] v[4] = '{8'hA1, 8'hA2, 8'hA3, 8'h55};
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hA0 + 8'(i));
    step(1, 1, 0, 8'h55);
    n_tests++; if (P !== 8'hA0 || count !== 3'd4 || pvalid !== 1'b1) begin n_fail++; $display("FAIL full_pp P=%h count=%0d exp A0/4", P, count); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00);
      n_tests++; if (P !== v[i]) begin n_fail++; $display("FAIL full_pp_pop[%0d] P=%h exp %h", i, P, v[i]); end
    end
  endtask

  task automatic test_empty_push_pop();
    step(1, 1, 0, 8'h77);
    n_tests++; if (P !== 8'h55 || pvalid !== 1'b0 || count !== 3'd1 || underflow !== exp_unf()) begin n_fail++; $display("FAIL empty_pp P=%h pvalid=%b count=%0d unf=%b exp 55/0/1/%b", P, pvalid, count, underflow, exp_unf()); end
    step(1, 0, 0, 8'h00);
    n_tests++; if (P !== 8'h77 || w_dut !== exp_vec()) begin n_fail++; $display("FAIL empty_pp_next P=%h exp 77", P); end
  endtask

  task automatic test_clear();
    step(0, 0, 1, 8'h00);
    n_tests++; if (underflow !== 1'b0 || w_dut !== exp_vec()) begin n_fail++; $display("FAIL clear_flags dut=%h exp=%h", w_dut, exp_vec()); end
    step(0, 1, 0, 8'h01);
    step(0, 1, 0, 8'h02);
    step(1, 1, 1, 8'h99);
    n_tests++; if (P !== 8'h01 || pvalid !== 1'b1 || count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL clear_pp P=%h pvalid=%b count=%0d empty=%b exp 01/1/0/1", P, pvalid, count, empty); end
    step(1, 0, 0, 8'h00);
    n_tests++; if (pvalid !== 1'b0 || P !== 8'h01 || w_dut !== exp_vec()) begin n_fail++; $display("FAIL clear_after pvalid=%b P=%h exp 0/01", pvalid, P); end
    step(0, 0, 1, 8'h00);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'($urandom));
    step(0, 1, 0, 8'hEE);
    n_tests++; if (count !== 3'd4 || overflow !== exp_unf()) begin n_fail++; $display("FAIL overflow count=%0d ovf=%b exp 4/%b", count, overflow, exp_unf()); end
    step(0, 0, 0, 8'h00);
    n_tests++; if (overflow !== exp_unf()) begin n_fail++; $display("FAIL overflow_hold ovf=%b exp %b", overflow, exp_unf()); end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 8'h00);
      n_tests++; if (w_dut !== exp_vec()) begin n_fail++; $display("FAIL overflow_drain[%0d] dut=%h exp=%h", i, w_dut, exp_vec()); end
    end
    step(0, 0, 1, 8'h00);
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear ovf=%b exp 0", overflow); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 8'hC0 + 8'(i));
    step(1, 0, 0, 8'h00);
    #2 reset = 1'b1;
    model_reset();
    #1;
    n_tests++; if (count !== 3'd0 || empty !== 1'b1 || P !== 8'h00 || pvalid !== 1'b0) begin n_fail++; $display("FAIL async_reset count=%0d empty=%b P=%h pvalid=%b exp 0/1/00/0", count, empty, P, pvalid); end
    #1 reset = 1'b0;
    step(1, 0, 0, 8'h00);
    n_tests++; if (pvalid !== 1'b0 || w_dut !== exp_vec()) begin n_fail++; $display("FAIL post_reset dut=%h exp=%h", w_dut, exp_vec()); end
    step(0, 0, 1, 8'h00);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0, 8'($urandom));
      n_tests++;
      if (w_dut !== exp_vec()) begin
        n_fail++;
        if (bad++ < 10) $display("FAIL random[%0d] dut=%h exp=%h", i, w_dut, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_push_pop();
    test_empty_push_pop();
    test_clear();
    test_overflow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
